// File: rtl/filter_window_sequencer_pkg.sv
// rtl/filter_window_sequencer_pkg.sv - shared defaults, FSM states and helpers for the 3x3 window sequencer
package filter_window_sequencer_pkg;
  localparam int IMG_W_DEF  = 224;
  localparam int IMG_H_DEF  = 224;
  localparam int K_DEF      = 3;
  localparam int ADDR_W_DEF = 16;
  localparam int RD_LAT_DEF = 1;
  localparam int TAP_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic int out_dim(input int dim, input int k);
    return dim - k + 1;
  endfunction
endpackage

// File: rtl/filter_window_sequencer_window_addr_gen.sv
// rtl/filter_window_sequencer_window_addr_gen.sv - row/col/tap walker producing neighbourhood read addresses
module window_addr_gen
  import filter_window_sequencer_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int K      = K_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr,
  output logic [TAP_W-1:0]  tap,
  output logic              last_tap,
  output logic              last_pixel
);
  localparam int OUT_W = out_dim(IMG_W, K);
  localparam int OUT_H = out_dim(IMG_H, K);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [TAP_W-1:0]  tap_q, tap_d, kx_q, kx_d;
  logic [ADDR_W-1:0] base_q, base_d, off_q, off_d;

  assign last_tap   = (tap_q == TAP_W'(K * K - 1));
  assign last_pixel = (row_q == ROW_W'(OUT_H - 1)) && (col_q == COL_W'(OUT_W - 1));
  assign addr       = base_q + off_q;
  assign tap        = tap_q;

  // base tracks row*IMG_W+col, off tracks ky*IMG_W+kx; both advance by adds only
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    tap_d  = tap_q;
    kx_d   = kx_q;
    base_d = base_q;
    off_d  = off_q;
    if (clr) begin
      row_d  = '0;
      col_d  = '0;
      tap_d  = '0;
      kx_d   = '0;
      base_d = '0;
      off_d  = '0;
    end else if (adv) begin
      if (last_tap) begin
        tap_d = '0;
        kx_d  = '0;
        off_d = '0;
        if (col_q == COL_W'(OUT_W - 1)) begin
          col_d  = '0;
          row_d  = row_q + 1'b1;
          base_d = base_q + ADDR_W'(K);
        end else begin
          col_d  = col_q + 1'b1;
          base_d = base_q + 1'b1;
        end
      end else begin
        tap_d = tap_q + 1'b1;
        if (kx_q == TAP_W'(K - 1)) begin
          kx_d  = '0;
          off_d = off_q + ADDR_W'(IMG_W - K + 1);
        end else begin
          kx_d  = kx_q + 1'b1;
          off_d = off_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= '0;
      col_q  <= '0;
      tap_q  <= '0;
      kx_q   <= '0;
      base_q <= '0;
      off_q  <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      tap_q  <= tap_d;
      kx_q   <= kx_d;
      base_q <= base_d;
      off_q  <= off_d;
    end
  end
endmodule

// File: rtl/filter_window_sequencer.sv
// rtl/filter_window_sequencer.sv - FSM, read-latency delay line and edge-RAM write counter for the 3x3 filter
module filter_window_sequencer
  import filter_window_sequencer_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int K      = K_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk_25,
  input  logic              rst_n,
  input  logic              locked,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic [TAP_W-1:0]  tap_idx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              finished
);
  state_e                        state_q, state_d;
  logic                          rd_en_q, rd_en_d, rd_clr_q, rd_clr_d;
  logic [ADDR_W-1:0]             rd_addr_q, rd_addr_d;
  logic [TAP_W-1:0]              rd_tap_q, rd_tap_d;
  logic [RD_LAT-1:0]             en_pipe_q, en_pipe_d, clr_pipe_q, clr_pipe_d;
  logic [RD_LAT-1:0][TAP_W-1:0]  tap_pipe_q, tap_pipe_d;
  logic                          wr_en_q, wr_en_d, busy_q, busy_d, finished_q, finished_d;
  logic [ADDR_W-1:0]             wr_addr_q, wr_addr_d, wr_cnt_q, wr_cnt_d;
  logic [2:0]                    drain_q, drain_d;
  logic                          gen_clr, gen_adv, gen_last_tap, gen_last_pixel;
  logic [ADDR_W-1:0]             gen_addr;
  logic [TAP_W-1:0]              gen_tap;

  window_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(ADDR_W)) u_addr_gen (
    .clk(clk_25), .rst_n(rst_n), .clr(gen_clr), .adv(gen_adv),
    .addr(gen_addr), .tap(gen_tap), .last_tap(gen_last_tap), .last_pixel(gen_last_pixel)
  );

  always_comb begin
    state_d    = state_q;
    rd_en_d    = 1'b0;
    rd_clr_d   = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_tap_d   = rd_tap_q;
    busy_d     = busy_q;
    finished_d = finished_q;
    drain_d    = drain_q;
    wr_cnt_d   = wr_cnt_q;
    wr_addr_d  = wr_addr_q;
    gen_clr    = 1'b0;
    gen_adv    = 1'b0;
    en_pipe_d[0]  = rd_en_q;
    clr_pipe_d[0] = rd_clr_q;
    tap_pipe_d[0] = rd_tap_q;
    for (int i = 1; i < RD_LAT; i++) begin
      en_pipe_d[i]  = en_pipe_q[i-1];
      clr_pipe_d[i] = clr_pipe_q[i-1];
      tap_pipe_d[i] = tap_pipe_q[i-1];
    end
    // the MAC result for the last tap is ready one cycle after it is consumed
    wr_en_d = en_pipe_q[RD_LAT-1] && (tap_pipe_q[RD_LAT-1] == TAP_W'(K * K - 1));
    if (wr_en_d) begin
      wr_addr_d = wr_cnt_q;
      wr_cnt_d  = wr_cnt_q + 1'b1;
    end
    if ((state_q == ST_IDLE && start && locked) || (state_q == ST_RUN && locked)) begin
      rd_en_d   = 1'b1;
      rd_clr_d  = (gen_tap == '0);
      rd_addr_d = gen_addr;
      rd_tap_d  = gen_tap;
      gen_adv   = 1'b1;
    end
    case (state_q)
      ST_IDLE: if (start && locked) begin
        state_d    = ST_RUN;
        busy_d     = 1'b1;
        finished_d = 1'b0;
        wr_cnt_d   = '0;
      end
      ST_RUN: if (locked && gen_last_tap && gen_last_pixel) begin
        state_d = ST_DRAIN;
        drain_d = '0;
        gen_clr = 1'b1;
      end
      ST_DRAIN: if (drain_q == 3'(RD_LAT + 1)) begin
        state_d    = ST_DONE;
        busy_d     = 1'b0;
        finished_d = 1'b1;
      end else begin
        drain_d = drain_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // losing clock lock flushes everything in flight without reporting completion
    if ((state_q == ST_RUN || state_q == ST_DRAIN) && !locked) begin
      state_d    = ST_IDLE;
      busy_d     = 1'b0;
      rd_en_d    = 1'b0;
      wr_en_d    = 1'b0;
      en_pipe_d  = '0;
      clr_pipe_d = '0;
      gen_clr    = 1'b1;
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_en_q    <= 1'b0;
      rd_clr_q   <= 1'b0;
      rd_addr_q  <= '0;
      rd_tap_q   <= '0;
      en_pipe_q  <= '0;
      clr_pipe_q <= '0;
      tap_pipe_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_cnt_q   <= '0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      drain_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      rd_clr_q   <= rd_clr_d;
      rd_addr_q  <= rd_addr_d;
      rd_tap_q   <= rd_tap_d;
      en_pipe_q  <= en_pipe_d;
      clr_pipe_q <= clr_pipe_d;
      tap_pipe_q <= tap_pipe_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_cnt_q   <= wr_cnt_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
      drain_q    <= drain_d;
    end
  end

  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign acc_en   = en_pipe_q[RD_LAT-1];
  assign acc_clr  = clr_pipe_q[RD_LAT-1];
  assign tap_idx  = tap_pipe_q[RD_LAT-1];
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign busy     = busy_q;
  assign finished = finished_q;
endmodule

// File: tb/tb_filter_window_sequencer.sv
// tb/tb_filter_window_sequencer.sv - scoreboard bench: full-size image (RD_LAT=1) and small image (RD_LAT=3)
module tb_filter_window_sequencer;
  localparam int AW = 16;

  logic clk = 1'b0, rst_n = 1'b0, locked = 1'b0, start_a = 1'b0, start_b = 1'b0;
  logic rd_en_a, acc_clr_a, acc_en_a, wr_en_a, busy_a, finished_a;
  logic rd_en_b, acc_clr_b, acc_en_b, wr_en_b, busy_b, finished_b;
  logic [AW-1:0] rd_addr_a, wr_addr_a, rd_addr_b, wr_addr_b;
  logic [3:0] tap_idx_a, tap_idx_b;

  filter_window_sequencer #(.IMG_W(224), .IMG_H(224), .K(3), .ADDR_W(AW), .RD_LAT(1)) dut_a (
    .clk_25(clk), .rst_n(rst_n), .locked(locked), .start(start_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .acc_clr(acc_clr_a), .acc_en(acc_en_a),
    .tap_idx(tap_idx_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .busy(busy_a), .finished(finished_a)
  );

  filter_window_sequencer #(.IMG_W(6), .IMG_H(5), .K(3), .ADDR_W(AW), .RD_LAT(3)) dut_b (
    .clk_25(clk), .rst_n(rst_n), .locked(locked), .start(start_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .acc_clr(acc_clr_b), .acc_en(acc_en_b),
    .tap_idx(tap_idx_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .busy(busy_b), .finished(finished_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int d; int c; int v; } evt_t;
  evt_t rd_q[$], acc_q[$], wr_q[$];
  int n_cmp = 0, n_err = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic pop_chk(input int kind, input int d, input int v);
    evt_t e;
    string nm;
    int sz;
    nm = (kind == 0) ? "rd" : (kind == 1) ? "acc" : "wr";
    sz = (kind == 0) ? rd_q.size() : (kind == 1) ? acc_q.size() : wr_q.size();
    n_cmp++;
    if (sz == 0) begin
      n_err++;
      $display("FAIL %s_unexpected: dut%0d cycle %0d value %0d, expected no event", nm, d, cyc, v);
      return;
    end
    case (kind)
      0: e = rd_q.pop_front();
      1: e = acc_q.pop_front();
      default: e = wr_q.pop_front();
    endcase
    if (e.d != d || e.c != cyc || e.v != v) begin
      n_err++;
      $display("FAIL %s_event: got dut%0d cycle %0d value %0d, expected dut%0d cycle %0d value %0d",
               nm, d, cyc, v, e.d, e.c, e.v);
    end
  endtask

  // expected reads/MAC strobes/writes of a run started at cycle s, up to and including cycle lim
  task automatic push_run(input int d, input int s, input int w, input int ow, input int npix,
                          input int lat, input int lim);
    int row, col, c;
    for (int n = 0; n < npix; n++) begin
      row = n / ow;
      col = n % ow;
      for (int t = 0; t < 9; t++) begin
        c = s + 1 + 9 * n + t;
        if (c <= lim) rd_q.push_back('{d, c, (row + t / 3) * w + col + t % 3});
        if (c + lat <= lim) acc_q.push_back('{d, c + lat, ((t == 0) ? 16 : 0) + t});
      end
      c = s + 10 + 9 * n + lat;
      if (c <= lim) wr_q.push_back('{d, c, n});
    end
  endtask

  always @(negedge clk) begin
    if (rd_en_a) pop_chk(0, 0, int'(rd_addr_a));
    if (acc_en_a) pop_chk(1, 0, int'(acc_clr_a) * 16 + int'(tap_idx_a));
    if (wr_en_a) pop_chk(2, 0, int'(wr_addr_a));
    if (rd_en_b) pop_chk(0, 1, int'(rd_addr_b));
    if (acc_en_b) pop_chk(1, 1, int'(acc_clr_b) * 16 + int'(tap_idx_b));
    if (wr_en_b) pop_chk(2, 1, int'(wr_addr_b));
  end

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_flags_a"}, int'({rd_en_a, acc_en_a, acc_clr_a, wr_en_a, busy_a, finished_a, tap_idx_a}), 0);
    check({nm, "_addr_a"}, int'(rd_addr_a | wr_addr_a), 0);
    check({nm, "_flags_b"}, int'({rd_en_b, acc_en_b, acc_clr_b, wr_en_b, busy_b, finished_b, tap_idx_b}), 0);
    check({nm, "_addr_b"}, int'(rd_addr_b | wr_addr_b), 0);
  endtask

  task automatic check_queues_empty(input string nm);
    check({nm, "_rd_left"}, rd_q.size(), 0);
    check({nm, "_acc_left"}, acc_q.size(), 0);
    check({nm, "_wr_left"}, wr_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    int tbl_a[9];
    int tbl_b[9];
    tbl_a = '{0, 1, 2, 224, 225, 226, 448, 449, 450};
    tbl_b = '{0, 1, 2, 6, 7, 8, 12, 13, 14};

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // start while the clock manager is not locked must be ignored
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    check("nolock_busy", int'(busy_a), 0);
    check("nolock_rd_en", int'(rd_en_a), 0);
    locked = 1'b1;
    repeat (2) @(negedge clk);

    // full-size run, aborted by dropping locked while pixel 1000 tap 0 is on the bus
    @(negedge clk);
    s = cyc;
    push_run(0, s, 224, 222, 1001, 1, s + 9001);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 0;
    check("run_busy", int'(busy_a), 1);
    check("run_finished", int'(finished_a), 0);
    for (int k = 1; k <= 9; k++) begin
      to_cyc(s + k);
      check("c1_rd_addr", int'(rd_addr_a), tbl_a[k-1]);
      if (k == 2) check("c1_acc_clr_tap0", int'(acc_clr_a), 1);
      if (k == 3) check("c1_acc_clr_tap1", int'(acc_clr_a), 0);
    end
    to_cyc(s + 10);
    check("c1_wr_en_early", int'(wr_en_a), 0);
    to_cyc(s + 11);
    check("c1_wr_en", int'(wr_en_a), 1);
    check("c1_wr_addr", int'(wr_addr_a), 0);
    to_cyc(s + 50);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    to_cyc(s + 1990);
    check("wrap_rd_pix221", int'(rd_addr_a), 221);
    to_cyc(s + 1999);
    check("wrap_rd_pix222", int'(rd_addr_a), 224);
    to_cyc(s + 2000);
    check("wrap_wr_221", int'(wr_addr_a), 221);
    to_cyc(s + 2009);
    check("wrap_wr_222", int'(wr_addr_a), 222);
    to_cyc(s + 9001);
    locked = 1'b0;
    @(negedge clk);
    check("abort_rd_en", int'(rd_en_a), 0);
    check("abort_wr_en", int'(wr_en_a), 0);
    check("abort_acc_en", int'(acc_en_a), 0);
    check("abort_busy", int'(busy_a), 0);
    check("abort_finished", int'(finished_a), 0);
    repeat (4) @(negedge clk);
    check("abort_finished_hold", int'(finished_a), 0);
    check_queues_empty("abort");

    // restart after abort, then asynchronous reset mid-run
    locked = 1'b1;
    @(negedge clk);
    s = cyc;
    push_run(0, s, 224, 222, 3, 1, s + 20);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("restart_rd_addr", int'(rd_addr_a), 0);
    check("restart_rd_en", int'(rd_en_a), 1);
    to_cyc(s + 20);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    repeat (3) @(negedge clk);
    check_queues_empty("async_rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // small image, RD_LAT=3, run to completion
    @(negedge clk);
    s = cyc;
    push_run(1, s, 6, 4, 12, 3, s + 1000);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      to_cyc(s + k);
      check("c6_rd_addr", int'(rd_addr_b), tbl_b[k-1]);
    end
    to_cyc(s + 12);
    check("c6_wr_en_early", int'(wr_en_b), 0);
    to_cyc(s + 13);
    check("c6_wr_en", int'(wr_en_b), 1);
    check("c6_wr_addr", int'(wr_addr_b), 0);
    to_cyc(s + 112);
    check("last_wr_en", int'(wr_en_b), 1);
    check("last_wr_addr", int'(wr_addr_b), 11);
    check("last_wr_finished", int'(finished_b), 0);
    check("last_wr_busy", int'(busy_b), 1);
    to_cyc(s + 113);
    check("done_finished", int'(finished_b), 1);
    check("done_busy", int'(busy_b), 0);
    check("done_wr_en", int'(wr_en_b), 0);
    to_cyc(s + 120);
    check("finished_hold", int'(finished_b), 1);
    check_queues_empty("full_run");

    // next start clears finished; abort it early
    @(negedge clk);
    s = cyc;
    push_run(1, s, 6, 4, 1, 3, s + 5);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("rerun_finished_clr", int'(finished_b), 0);
    check("rerun_busy", int'(busy_b), 1);
    to_cyc(s + 5);
    locked = 1'b0;
    @(negedge clk);
    check("rerun_abort_rd_en", int'(rd_en_b), 0);
    check("rerun_abort_acc_en", int'(acc_en_b), 0);
    check("rerun_abort_busy", int'(busy_b), 0);
    repeat (6) @(negedge clk);
    check_queues_empty("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
